tt_loopback_checker: RTL and testbench

TT_LOOPBACK_CHECKER -- requirements
Module: tt_loopback_checker

---
 rtl/tt_lbchk_pkg.sv | 46 ++++
 rtl/tt_lbchk_patgen.sv | 43 ++++
 rtl/tt_loopback_checker.sv | 160 ++++++++++++++++
 tb/tb_tt_loopback_checker.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_lbchk_pkg.sv
// Shared types and constants for the loopback checker: FSM states, pattern
// mode encodings, LFSR parameters and the expected-value delay line entry.
package tt_lbchk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [1:0] MODE_COUNTER = 2'd0;
  localparam logic [1:0] MODE_WALK1   = 2'd1;
  localparam logic [1:0] MODE_WALK0   = 2'd2;
  localparam logic [1:0] MODE_LFSR    = 2'd3;

  localparam logic [7:0] LFSR_SEED = 8'h01;
  // Feedback taps at bits 7, 5, 4 and 3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam int unsigned DL_DEPTH = 4;

  typedef struct packed {
    logic       valid;
    logic [7:0] exp;
    logic [7:0] idx;
  } dl_entry_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

  function automatic logic [7:0] pattern(input logic [1:0] mode,
                                         input logic [7:0] k,
                                         input logic [7:0] lfsr);
    logic [7:0] walk;
    walk = 8'h01 << k[2:0];
    case (mode)
      MODE_COUNTER: return k;
      MODE_WALK1:   return walk;
      MODE_WALK0:   return ~walk;
      default:      return lfsr;
    endcase
  endfunction

endpackage

// File: rtl/tt_lbchk_patgen.sv
// Stimulus vector generator. vec/idx describe the vector that will be current
// after this edge, so the checker can register it straight onto pat_out.
module tt_lbchk_patgen
  import tt_lbchk_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       load,
  input  logic       advance,
  output logic [7:0] vec,
  output logic [7:0] idx
);

  logic [7:0] k_q, k_d;
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    k_d    = k_q;
    lfsr_d = lfsr_q;
    if (load) begin
      k_d    = '0;
      lfsr_d = LFSR_SEED;
    end else if (advance) begin
      k_d    = k_q + 8'd1;
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  assign vec = pattern(mode, k_d, lfsr_d);
  assign idx = k_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q    <= '0;
      lfsr_q <= LFSR_SEED;
    end else begin
      k_q    <= k_d;
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/tt_loopback_checker.sv
// Loopback checker: drives a pattern run, compares the returned data against
// a delayed copy of each vector and reports error count and first failure.
module tt_loopback_checker
  import tt_lbchk_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [1:0] latency,
  output logic [7:0] pat_out,
  input  logic [7:0] pat_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] first_err_idx
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_VECTORS - 1);

  state_t     state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [1:0] lat_q, lat_d;
  logic [1:0] drain_q, drain_d;
  logic [7:0] pat_out_q, pat_out_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [7:0] err_q, err_d;
  logic [7:0] first_q, first_d;
  dl_entry_t [DL_DEPTH-1:0] dl_q, dl_d;

  logic       accept;
  logic       gen_load, gen_adv;
  logic [1:0] gen_mode;
  logic [7:0] gen_vec, gen_idx;
  dl_entry_t  tap;
  logic       mismatch;

  tt_lbchk_patgen u_patgen (
    .clk     (clk),
    .rst     (rst),
    .mode    (gen_mode),
    .load    (gen_load),
    .advance (gen_adv),
    .vec     (gen_vec),
    .idx     (gen_idx)
  );

  // The first vector of a run must use the mode presented with start.
  always_comb begin
    accept   = start && (state_q == ST_IDLE || state_q == ST_DONE);
    gen_load = accept;
    gen_adv  = (state_q == ST_DRIVE) && (dl_q[0].idx != LAST_IDX);
    gen_mode = accept ? mode : mode_q;
  end

  // Stage L-1 holds vector k during the cycle before the edge L after it was driven.
  assign tap      = dl_q[lat_q];
  assign mismatch = (state_q == ST_DRIVE || state_q == ST_DRAIN) &&
                    tap.valid && (pat_in != tap.exp);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    lat_d     = lat_q;
    drain_d   = drain_q;
    pat_out_d = pat_out_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    err_d     = err_q;
    first_d   = first_q;
    dl_d      = {dl_q[DL_DEPTH-2:0], dl_entry_t'('0)};

    if (mismatch) begin
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
      if (err_q == 8'h00) first_d = tap.idx;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d   = ST_DRIVE;
          mode_d    = mode;
          lat_d     = latency;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          err_d     = '0;
          first_d   = '0;
          pat_out_d = gen_vec;
          dl_d      = '0;
          dl_d[0]   = '{valid: 1'b1, exp: gen_vec, idx: gen_idx};
        end
      end
      ST_DRIVE: begin
        if (dl_q[0].idx == LAST_IDX) begin
          state_d   = ST_DRAIN;
          drain_d   = '0;
          pat_out_d = '0;
        end else begin
          pat_out_d = gen_vec;
          dl_d[0]   = '{valid: 1'b1, exp: gen_vec, idx: gen_idx};
        end
      end
      ST_DRAIN: begin
        pat_out_d = '0;
        if (drain_q == lat_q) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 8'h00);
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= '0;
      lat_q     <= '0;
      drain_q   <= '0;
      pat_out_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      first_q   <= '0;
      dl_q      <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      lat_q     <= lat_d;
      drain_q   <= drain_d;
      pat_out_q <= pat_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      first_q   <= first_d;
      dl_q      <= dl_d;
    end
  end

  assign pat_out       = pat_out_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_idx = first_q;

endmodule

// File: tb/tb_tt_loopback_checker.sv
// Scoreboard bench for tt_loopback_checker: a configurable loopback path feeds
// pat_out back to pat_in; expected vectors and run results are queued per run.
module tb_tt_loopback_checker;

  localparam int unsigned N = 256;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic [1:0] latency;
  logic [7:0] pat_out;
  logic [7:0] pat_in;
  logic       busy, done, pass;
  logic [7:0] err_count, first_err_idx;

  always #5 clk = ~clk;

  tt_loopback_checker #(.NUM_VECTORS(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .mode          (mode),
    .latency       (latency),
    .pat_out       (pat_out),
    .pat_in        (pat_in),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_idx (first_err_idx)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] err;
    logic [7:0] first;
    logic       pass;
  } result_t;

  logic [7:0] exp_vec_q[$];
  result_t    res_q[$];
  logic [7:0] vecs [N];

  // Loopback path: delay D counts edges from pat_out change to the sampling edge.
  int         lb_delay    = 1;
  logic [7:0] lb_mask     = 8'hFF;
  int         corrupt_tag = -1;
  logic [7:0] pipe [3];
  int         tag_pipe [3];
  int         tb_k = 0;
  logic [7:0] lb_val;
  int         lb_tag;

  always @(posedge clk) begin
    pipe[0]     <= pat_out;
    pipe[1]     <= pipe[0];
    pipe[2]     <= pipe[1];
    tag_pipe[0] <= tb_k;
    tag_pipe[1] <= tag_pipe[0];
    tag_pipe[2] <= tag_pipe[1];
    tb_k        <= start ? 0 : tb_k + 1;
  end

  always_comb begin
    lb_val = pat_out;
    lb_tag = tb_k;
    case (lb_delay)
      2: begin lb_val = pipe[0]; lb_tag = tag_pipe[0]; end
      3: begin lb_val = pipe[1]; lb_tag = tag_pipe[1]; end
      4: begin lb_val = pipe[2]; lb_tag = tag_pipe[2]; end
      default: ;
    endcase
    pat_in = (lb_val & lb_mask) ^ ((lb_tag == corrupt_tag) ? 8'h5A : 8'h00);
  end

  // Scoreboard monitor: every busy cycle must present the next queued vector.
  int         busy_cycles = 0;
  logic [7:0] mon_exp;
  always @(negedge clk) begin
    if (rst === 1'b0 && busy === 1'b1) begin
      busy_cycles++;
      checks++;
      if (exp_vec_q.size() == 0) begin
        errors++;
        $display("FAIL busy_extra: busy=%b with empty queue, required no busy cycle", busy);
      end else begin
        mon_exp = exp_vec_q.pop_front();
        if (pat_out !== mon_exp) begin
          errors++;
          $display("FAIL pat_out: got %02h, required %02h (cycle %0d)", pat_out, mon_exp,
                   busy_cycles - 1);
        end
      end
    end
  end

  task automatic build_vectors(input logic [1:0] m);
    logic [7:0] v = 8'h01;
    logic [7:0] kb;
    for (int k = 0; k < N; k++) begin
      kb = 8'(k);
      case (m)
        2'd0: vecs[k] = kb;
        2'd1: vecs[k] = 8'h01 << (k % 8);
        2'd2: vecs[k] = ~(8'h01 << (k % 8));
        default: vecs[k] = v;
      endcase
      v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    end
  endtask

  task automatic compute_expected(input int l, input int d);
    result_t    r;
    logic [7:0] src, rx;
    int         cnt = 0;
    int         j;
    r.first = 8'h00;
    for (int k = 0; k < N; k++) begin
      j   = k + l - d;
      src = (j < N) ? vecs[j] : 8'h00;
      rx  = (src & lb_mask) ^ ((j == corrupt_tag) ? 8'h5A : 8'h00);
      if (rx != vecs[k]) begin
        if (cnt == 0) r.first = 8'(k);
        if (cnt < 255) cnt++;
      end
    end
    r.err  = 8'(cnt);
    r.pass = (cnt == 0);
    res_q.push_back(r);
  endtask

  task automatic start_run(input logic [1:0] m, input logic [1:0] lat, input int d,
                           input logic [7:0] mask, input int corrupt);
    lb_delay    = d;
    lb_mask     = mask;
    corrupt_tag = corrupt;
    build_vectors(m);
    exp_vec_q.delete();
    for (int k = 0; k < N; k++) exp_vec_q.push_back(vecs[k]);
    for (int k = 0; k <= int'(lat); k++) exp_vec_q.push_back(8'h00);
    compute_expected(int'(lat) + 1, d);
    busy_cycles = 0;
    @(posedge clk); #1;
    mode = m; latency = lat; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mode = ~m; latency = ~lat;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL done_timeout: done=%b after 2000 cycles, required 1", done);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; mode = 2'd0; latency = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    checks += 6;
    if (pat_out !== 8'h00)       begin errors++; $display("FAIL rst_pat_out: got %02h, required 00", pat_out); end
    if (busy !== 1'b0)           begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    if (done !== 1'b0)           begin errors++; $display("FAIL rst_done: got %b, required 0", done); end
    if (pass !== 1'b0)           begin errors++; $display("FAIL rst_pass: got %b, required 0", pass); end
    if (err_count !== 8'h00)     begin errors++; $display("FAIL rst_err: got %0d, required 0", err_count); end
    if (first_err_idx !== 8'h00) begin errors++; $display("FAIL rst_first: got %0d, required 0", first_err_idx); end
    rst = 1'b0;
  endtask

  task automatic test_counter;
    bit ok;
    result_t r;
    start_run(2'd0, 2'd0, 1, 8'hFF, -1);
    wait_done(ok);
    r = res_q.pop_front();
    if (ok) begin
      checks += 5;
      if (busy_cycles != N + 1)  begin errors++; $display("FAIL cnt_cycles: got %0d, required %0d", busy_cycles, N + 1); end
      if (err_count !== r.err)   begin errors++; $display("FAIL cnt_err: got %0d, required %0d", err_count, r.err); end
      if (pass !== 1'b1)         begin errors++; $display("FAIL cnt_pass: got %b, required 1", pass); end
      if (busy !== 1'b0)         begin errors++; $display("FAIL cnt_busy: got %b, required 0", busy); end
      if (exp_vec_q.size() != 0) begin errors++; $display("FAIL cnt_queue: %0d vectors left, required 0", exp_vec_q.size()); end
    end
  endtask

  task automatic test_lfsr_stuck_bit;
    bit ok;
    result_t r;
    start_run(2'd3, 2'd3, 4, 8'hFB, -1);
    wait_done(ok);
    r = res_q.pop_front();
    if (ok) begin
      checks += 4;
      if (busy_cycles != N + 4)      begin errors++; $display("FAIL lfsr_cycles: got %0d, required %0d", busy_cycles, N + 4); end
      if (err_count !== r.err)       begin errors++; $display("FAIL lfsr_err: got %0d, required %0d", err_count, r.err); end
      if (first_err_idx !== r.first) begin errors++; $display("FAIL lfsr_first: got %0d, required %0d", first_err_idx, r.first); end
      if (pass !== r.pass)           begin errors++; $display("FAIL lfsr_pass: got %b, required %b", pass, r.pass); end
      repeat (5) @(negedge clk);
      checks += 2;
      if (err_count !== r.err) begin errors++; $display("FAIL lfsr_hold: got %0d, required %0d", err_count, r.err); end
      if (done !== 1'b1)       begin errors++; $display("FAIL lfsr_done_hold: got %b, required 1", done); end
    end
  endtask

  task automatic test_latency_mismatch;
    bit ok;
    result_t r;
    start_run(2'd1, 2'd1, 1, 8'hFF, -1);
    wait_done(ok);
    r = res_q.pop_front();
    if (ok) begin
      checks += 3;
      if (err_count !== r.err)       begin errors++; $display("FAIL lat_err: got %0d, required %0d", err_count, r.err); end
      if (first_err_idx !== r.first) begin errors++; $display("FAIL lat_first: got %0d, required %0d", first_err_idx, r.first); end
      if (pass !== r.pass)           begin errors++; $display("FAIL lat_pass: got %b, required %b", pass, r.pass); end
    end
  endtask

  task automatic test_reset_midrun;
    bit ok;
    result_t r;
    start_run(2'd0, 2'd1, 2, 8'hFF, -1);
    void'(res_q.pop_front());
    repeat (100) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    exp_vec_q.delete();
    checks += 5;
    if (pat_out !== 8'h00)       begin errors++; $display("FAIL mid_rst_pat_out: got %02h, required 00", pat_out); end
    if (busy !== 1'b0)           begin errors++; $display("FAIL mid_rst_busy: got %b, required 0", busy); end
    if (done !== 1'b0)           begin errors++; $display("FAIL mid_rst_done: got %b, required 0", done); end
    if (pass !== 1'b0)           begin errors++; $display("FAIL mid_rst_pass: got %b, required 0", pass); end
    if (err_count !== 8'h00 || first_err_idx !== 8'h00) begin
      errors++; $display("FAIL mid_rst_counts: got %0d/%0d, required 0/0", err_count, first_err_idx);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start_run(2'd3, 2'd1, 2, 8'hFF, -1);
    wait_done(ok);
    r = res_q.pop_front();
    if (ok) begin
      checks += 2;
      if (pass !== 1'b1)        begin errors++; $display("FAIL post_rst_pass: got %b, required 1", pass); end
      if (err_count !== r.err)  begin errors++; $display("FAIL post_rst_err: got %0d, required %0d", err_count, r.err); end
    end
  endtask

  task automatic test_start_ignored;
    bit ok;
    result_t r;
    start_run(2'd0, 2'd0, 1, 8'hFE, -1);
    repeat (50) @(negedge clk);
    @(posedge clk); #1;
    start = 1'b1; mode = 2'd1; latency = 2'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(ok);
    r = res_q.pop_front();
    if (ok) begin
      checks += 3;
      if (busy_cycles != N + 1)      begin errors++; $display("FAIL ign_cycles: got %0d, required %0d", busy_cycles, N + 1); end
      if (err_count !== r.err)       begin errors++; $display("FAIL ign_err: got %0d, required %0d", err_count, r.err); end
      if (first_err_idx !== r.first) begin errors++; $display("FAIL ign_first: got %0d, required %0d", first_err_idx, r.first); end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    result_t r;
    start_run(2'd2, 2'd2, 3, 8'hFF, 37);
    checks += 4;
    if (done !== 1'b0)           begin errors++; $display("FAIL b2b_done: got %b, required 0", done); end
    if (busy !== 1'b1)           begin errors++; $display("FAIL b2b_busy: got %b, required 1", busy); end
    if (err_count !== 8'h00)     begin errors++; $display("FAIL b2b_err_clr: got %0d, required 0", err_count); end
    if (first_err_idx !== 8'h00) begin errors++; $display("FAIL b2b_first_clr: got %0d, required 0", first_err_idx); end
    wait_done(ok);
    r = res_q.pop_front();
    if (ok) begin
      checks += 3;
      if (err_count !== r.err)       begin errors++; $display("FAIL b2b_err: got %0d, required %0d", err_count, r.err); end
      if (first_err_idx !== r.first) begin errors++; $display("FAIL b2b_first: got %0d, required %0d", first_err_idx, r.first); end
      if (pass !== r.pass)           begin errors++; $display("FAIL b2b_pass: got %b, required %b", pass, r.pass); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_counter();
    test_lfsr_stuck_bit();
    test_latency_mismatch();
    test_reset_midrun();
    test_start_ignored();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
